// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a final sign-fixup cycle and direct MTHI/MTLO writes.
module muldiv_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic [31:0] ma_reg, mb_reg;
    logic        sa_reg, sb_reg, signed_reg, isdiv_reg, dz_reg;
    logic [63:0] acc_reg;
    logic [31:0] rem_reg;
    logic        busy_reg, done_reg;
    logic [31:0] hi_reg, lo_reg;

    logic [63:0] mul_add;
    logic [32:0] rem_shift, diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rmd_fix;
    logic        neg_res;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && !op[2]) state_next = CALC;
            CALC:    if (cnt_reg == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_comb begin
        mul_add   = mb_reg[cnt_reg] ? ({32'b0, ma_reg} << cnt_reg) : 64'b0;
        // Dividend bits enter MSB first, so step cnt consumes bit 31-cnt.
        rem_shift = {rem_reg, ma_reg[~cnt_reg]};
        diff      = rem_shift - {1'b0, mb_reg};
        neg_res   = signed_reg && (sa_reg ^ sb_reg);
        prod_fix  = neg_res ? -acc_reg : acc_reg;
        // A zero divisor leaves quotient all ones and remainder |a|; negating
        // the remainder for a negative dividend restores a as issued.
        quo_fix   = (neg_res && !dz_reg) ? -acc_reg[31:0] : acc_reg[31:0];
        rmd_fix   = (signed_reg && sa_reg) ? -rem_reg : rem_reg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            ma_reg     <= '0;
            mb_reg     <= '0;
            sa_reg     <= 1'b0;
            sb_reg     <= 1'b0;
            signed_reg <= 1'b0;
            isdiv_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            acc_reg    <= '0;
            rem_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: if (start && !flush) begin
                    if (!op[2]) begin
                        ma_reg     <= (!op[0] && a[31]) ? -a : a;
                        mb_reg     <= (!op[0] && b[31]) ? -b : b;
                        sa_reg     <= a[31];
                        sb_reg     <= b[31];
                        signed_reg <= !op[0];
                        isdiv_reg  <= op[1];
                        dz_reg     <= (b == '0);
                        cnt_reg    <= '0;
                        acc_reg    <= '0;
                        rem_reg    <= '0;
                    end else if (op == 3'd4) begin
                        hi_reg <= a;
                    end else if (op == 3'd5) begin
                        lo_reg <= a;
                    end
                end
                CALC: if (!flush) begin
                    cnt_reg <= cnt_reg + 5'd1;
                    if (isdiv_reg) begin
                        rem_reg <= diff[32] ? rem_shift[31:0] : diff[31:0];
                        acc_reg <= {32'b0, acc_reg[30:0], !diff[32]};
                    end else begin
                        acc_reg <= acc_reg + mul_add;
                    end
                end
                FIX: if (!flush) begin
                    done_reg <= 1'b1;
                    if (isdiv_reg) begin
                        hi_reg <= rmd_fix;
                        lo_reg <= quo_fix;
                    end else begin
                        hi_reg <= prod_fix[63:32];
                        lo_reg <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
